// File: rtl/cam_init_pkg.sv
// Shared definitions for the camera init sequencer: FSM encoding, ROM word
// field positions and the default OV7725 SCCB write address.
package cam_init_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_ROMWAIT = 4'd2,
    ST_LOAD    = 4'd3,
    ST_REQ     = 4'd4,
    ST_GAP     = 4'd5,
    ST_SWDLY   = 4'd6,
    ST_ADV     = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } state_t;

  // ROM word layout: {reg_addr, reg_data}
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = REG_LSB - 1;

  localparam logic [7:0] OV7725_DEV_ID = 8'h42;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/init_delay_counter.sv
// Down-counting delay timer shared by the power-up and soft-reset waits.
// start loads the count; expired is high for the one cycle in which the
// loaded count has run down to zero.
module init_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load,
  output logic             busy,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  // load on start, otherwise count down to terminal count and go idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= load;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign expired = busy && (cnt == '0);

endmodule

// File: rtl/camera_init_sequencer.sv
// Walks the camera init ROM and issues one SCCB register write per entry,
// retrying NACKed entries, inserting the post-soft-reset settle delay and
// reporting done/error to the capture path.
//
// state   | meaning
// --------+---------------------------------------------------------------
// PWRUP   | power-up settle wait before the first write
// FETCH   | drive rom_addr with the current index
// ROMWAIT | one cycle for the registered ROM read
// LOAD    | latch register address/data from rom_q, raise sccb_req
// REQ     | hold sccb_req until the master reports done
// GAP     | one req-low cycle before retrying a NACKed entry
// SWDLY   | settle wait after the soft-reset entry (index 0)
// ADV     | move to the next entry or finish
// DONE    | all entries written; waits for restart
// ERROR   | an entry ran out of retries; waits for restart
module camera_init_sequencer
  import cam_init_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 8,
  parameter int         DATA_WIDTH   = 16,
  parameter int         REG_NUM      = 68,
  parameter logic [7:0] DEVICE_ID    = OV7725_DEV_ID,
  parameter int         PWRUP_CYCLES = 1250000,
  parameter int         SWRST_CYCLES = 50000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  sccb_req,
  output logic [7:0]            sccb_dev_id,
  output logic [7:0]            sccb_reg,
  output logic [7:0]            sccb_wdata,
  input  logic                  sccb_done,
  input  logic                  sccb_nack,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
);

  localparam int DLY_W = $clog2(max_int(PWRUP_CYCLES, SWRST_CYCLES) + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The cycle spent arming the timer counts as one of the power-up cycles,
  // so the FSM leaves PWRUP exactly PWRUP_CYCLES clocks after reset release.
  localparam logic [DLY_W-1:0] PWRUP_LOAD =
    DLY_W'((PWRUP_CYCLES >= 2) ? PWRUP_CYCLES - 2 : 0);
  // Armed on the entry-0 done edge, so SWDLY lasts exactly SWRST_CYCLES.
  localparam logic [DLY_W-1:0] SWRST_LOAD =
    DLY_W'((SWRST_CYCLES >= 1) ? SWRST_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_NUM - 1);
  localparam logic [RTY_W-1:0]      RETRY_MAX = RTY_W'(MAX_RETRY);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [RTY_W-1:0]        retry;
  logic                    dly_start;
  logic [DLY_W-1:0]        dly_load;
  logic                    dly_busy;
  logic                    dly_expired;

  assign sccb_dev_id = DEVICE_ID;

  // arm the shared timer on entry to PWRUP and on the entry-0 success edge
  always_comb begin
    dly_start = 1'b0;
    dly_load  = PWRUP_LOAD;
    if (state == ST_PWRUP && !dly_busy) begin
      dly_start = 1'b1;
    end else if (state == ST_REQ && sccb_done && !sccb_nack && idx == '0) begin
      dly_start = 1'b1;
      dly_load  = SWRST_LOAD;
    end
  end

  init_delay_counter #(
    .WIDTH (DLY_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (dly_start),
    .load    (dly_load),
    .busy    (dly_busy),
    .expired (dly_expired)
  );

  // sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PWRUP;
      idx        <= '0;
      retry      <= '0;
      rom_addr   <= '0;
      sccb_req   <= 1'b0;
      sccb_reg   <= '0;
      sccb_wdata <= '0;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      err_index  <= '0;
    end else begin
      case (state)
        ST_PWRUP: begin
          init_busy <= 1'b1;
          if (dly_expired) state <= ST_FETCH;
        end
        ST_FETCH: begin
          rom_addr <= idx;
          state    <= ST_ROMWAIT;
        end
        ST_ROMWAIT: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          sccb_reg   <= rom_q[REG_MSB:REG_LSB];
          sccb_wdata <= rom_q[DATA_MSB:0];
          sccb_req   <= 1'b1;
          state      <= ST_REQ;
        end
        ST_REQ: begin
          if (sccb_done) begin
            sccb_req <= 1'b0;
            if (!sccb_nack) begin
              retry <= '0;
              state <= (idx == '0) ? ST_SWDLY : ST_ADV;
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 1'b1;
              state <= ST_GAP;
            end else begin
              err_index <= idx;
              init_err  <= 1'b1;
              init_busy <= 1'b0;
              state     <= ST_ERROR;
            end
          end
        end
        ST_GAP: begin
          sccb_req <= 1'b1;
          state    <= ST_REQ;
        end
        ST_SWDLY: begin
          if (dly_expired) state <= ST_ADV;
        end
        ST_ADV: begin
          if (idx == LAST_IDX) begin
            init_done <= 1'b1;
            init_busy <= 1'b0;
            state     <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (restart) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
            init_busy <= 1'b1;
            idx       <= '0;
            retry     <= '0;
            state     <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule
